counter_access_ctrl: RTL and testbench

- Sequencer and arbiter in front of the shared up/down counter (increment/decrement/count interface).
- Takes increment/decrement requests from NUM_REQ requesters and grants them round-robin.
- Drives single-cycle increment/decrement commands into the counter.
- Blocks overflow and underflow, and checks after every command that the counter actually moved.

---
 rtl/counter_access_if.sv | 26 ++
 rtl/counter_access_ctrl.sv | 126 ++++++++++++
 tb/tb_counter_access_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/counter_access_if.sv
// Requester and counter-side signals of the counter access controller.
// The controller uses the slave modport. The environment (requesters plus counter) uses the master modport.
interface counter_access_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 2
);
    logic [NUM_REQ-1:0] req_inc;
    logic [NUM_REQ-1:0] req_dec;
    logic [NUM_REQ-1:0] ack;
    logic [NUM_REQ-1:0] nack;
    logic               increment;
    logic               decrement;
    logic [CNT_W-1:0]   count;
    logic               busy;
    logic               err;

    modport master (
        output req_inc, req_dec, count,
        input  ack, nack, increment, decrement, busy, err
    );

    modport slave (
        input  req_inc, req_dec, count,
        output ack, nack, increment, decrement, busy, err
    );
endinterface

// File: rtl/counter_access_ctrl.sv
// Round-robin sequencer in front of a shared up/down counter.
// It blocks overflow and underflow, and it checks that every command moved the counter.
module counter_access_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    counter_access_if.slave        bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   exp_q, exp_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] nack_q, nack_d;
    logic               increment_q, increment_d;
    logic               decrement_q, decrement_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   idx;
    logic               win_inc;
    logic               reject;

    // Scan from the highest offset down, so the last hit is the lowest offset from rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (bus.req_inc[idx] || bus.req_dec[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_inc = bus.req_inc[win];
        reject  = (bus.req_inc[win] && bus.req_dec[win]) ||
                  ( win_inc && (bus.count == CNT_MAX)) ||
                  (!win_inc && (bus.count == '0));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            exp_q       <= '0;
            ack_q       <= '0;
            nack_q      <= '0;
            increment_q <= 1'b0;
            decrement_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            exp_q       <= exp_d;
            ack_q       <= ack_d;
            nack_q      <= nack_d;
            increment_q <= increment_d;
            decrement_q <= decrement_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        exp_d    = exp_q;
        case (state_q)
            IDLE: if (found) begin
                win_d    = win;
                rr_ptr_d = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                exp_d    = win_inc ? bus.count + CNT_W'(1) : bus.count - CNT_W'(1);
                state_d  = reject ? DONE : ISSUE;
            end
            ISSUE:   state_d = SETTLE;
            SETTLE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so that every port comes straight from a flop.
    always_comb begin
        ack_d       = '0;
        nack_d      = '0;
        increment_d = 1'b0;
        decrement_d = 1'b0;
        err_d       = err_q;
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: if (found) begin
                if (reject) begin
                    nack_d[win] = 1'b1;
                end else begin
                    increment_d = win_inc;
                    decrement_d = !win_inc;
                end
            end
            SETTLE: begin
                if (bus.count != exp_q) err_d = 1'b1;
                ack_d[win_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ack       = ack_q;
    assign bus.nack      = nack_q;
    assign bus.increment = increment_q;
    assign bus.decrement = decrement_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_counter_access_ctrl.sv
// Directed bench for counter_access_ctrl with a behavioural up/down counter.
// The counter can be stalled to provoke the sticky err flag.
module tb_counter_access_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0;
    logic [1:0] cnt;
    logic       e_err = 1'b0;
    int         checks = 0;
    int         errors = 0;

    counter_access_if #(.NUM_REQ(4), .CNT_W(2)) bus ();

    counter_access_ctrl #(.NUM_REQ(4), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset)                         cnt <= 2'd0;
        else if (!stall && bus.increment)   cnt <= cnt + 2'd1;
        else if (!stall && bus.decrement)   cnt <= cnt - 2'd1;
    end
    assign bus.count = cnt;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] outs();
        return {bus.ack, bus.nack, bus.increment, bus.decrement, bus.busy, bus.err};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        e_err = 1'b0;
        chk("reset_outs", outs(), 12'h000);
        chk("reset_cnt", {10'b0, bus.count}, 12'h000);
        reset = 1'b1;
    endtask

    // The caller has already raised the request. Each call starts on a negedge while the controller is in IDLE.
    task automatic do_acc(input string tag, input int w, input bit inc, input logic [1:0] cnt_exp,
                          input bit err_new);
        logic [3:0]  oh;
        logic [11:0] e;
        oh = 4'b0001 << w;
        @(negedge clk);
        e = {8'b0, inc, ~inc, 1'b1, e_err};
        chk({tag, "_issue"}, outs(), e);
        @(negedge clk);
        e = {8'b0, 2'b00, 1'b1, e_err};
        chk({tag, "_settle"}, outs(), e);
        chk({tag, "_count"}, {10'b0, bus.count}, {10'b0, cnt_exp});
        e_err = e_err | err_new;
        @(negedge clk);
        e = {oh, 4'b0, 2'b00, 1'b1, e_err};
        chk({tag, "_ack"}, outs(), e);
        bus.req_inc[w] = 1'b0;
        bus.req_dec[w] = 1'b0;
        @(negedge clk);
        e = {10'b0, 1'b0, e_err};
        chk({tag, "_idle"}, outs(), e);
    endtask

    task automatic do_rej(input string tag, input int w, input logic [1:0] cnt_exp);
        logic [3:0]  oh;
        logic [11:0] e;
        oh = 4'b0001 << w;
        @(negedge clk);
        e = {4'b0, oh, 2'b00, 1'b1, e_err};
        chk({tag, "_nack"}, outs(), e);
        bus.req_inc[w] = 1'b0;
        bus.req_dec[w] = 1'b0;
        @(negedge clk);
        e = {10'b0, 1'b0, e_err};
        chk({tag, "_idle"}, outs(), e);
        chk({tag, "_count"}, {10'b0, bus.count}, {10'b0, cnt_exp});
    endtask

    initial begin
        bus.req_inc = '0;
        bus.req_dec = '0;
        @(negedge clk);
        do_reset();

        // 1: a single increment from 0. Afterwards rr_ptr is 1.
        bus.req_inc[0] = 1'b1;
        do_acc("t1", 0, 1'b1, 2'd1, 1'b0);

        // 2: fill the counter to MAX. An increment at MAX is then rejected.
        bus.req_inc[1] = 1'b1;
        do_acc("t2a", 1, 1'b1, 2'd2, 1'b0);
        bus.req_inc[2] = 1'b1;
        do_acc("t2b", 2, 1'b1, 2'd3, 1'b0);
        bus.req_inc[1] = 1'b1;
        do_rej("t2_ovf", 1, 2'd3);
        do_reset();
        bus.req_dec[2] = 1'b1;
        do_rej("t2_unf", 2, 2'd0);

        // 3: three requesters raise requests together. Grants go out in round-robin order 0, 2, 3.
        do_reset();
        bus.req_inc[0] = 1'b1;
        bus.req_inc[2] = 1'b1;
        bus.req_dec[3] = 1'b1;
        do_acc("t3_r0", 0, 1'b1, 2'd1, 1'b0);
        do_acc("t3_r2", 2, 1'b1, 2'd2, 1'b0);
        do_acc("t3_r3", 3, 1'b0, 2'd1, 1'b0);
        // rr_ptr has wrapped to 0, so requester 0 wins over requester 1.
        bus.req_dec[0] = 1'b1;
        bus.req_inc[1] = 1'b1;
        do_acc("t3_wrap0", 0, 1'b0, 2'd0, 1'b0);
        do_acc("t3_wrap1", 1, 1'b1, 2'd1, 1'b0);

        // 4: the same requester asks for both directions, so the request is rejected.
        bus.req_inc[1] = 1'b1;
        bus.req_dec[1] = 1'b1;
        do_rej("t4_both", 1, 2'd1);

        // 5: the counter is stalled. err sets, the ack is still issued, and err stays set until reset.
        stall = 1'b1;
        bus.req_inc[0] = 1'b1;
        do_acc("t5_stall", 0, 1'b1, 2'd1, 1'b1);
        stall = 1'b0;
        bus.req_inc[2] = 1'b1;
        do_acc("t5_sticky", 2, 1'b1, 2'd2, 1'b0);
        do_reset();

        // 6: reset arrives during ISSUE. The transaction is dropped, and the held request is granted again.
        bus.req_inc[3] = 1'b1;
        @(negedge clk);
        chk("t6_issue", outs(), {8'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        reset = 1'b0;
        @(negedge clk);
        chk("t6_dropped", outs(), 12'h000);
        reset = 1'b1;
        do_acc("t6_regrant", 3, 1'b1, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
